// File: rtl/unidade_controle_jogo_pkg.sv
// Shared definitions for the game control unit: state codes shown on the
// debug display and the default timeout parameters.
package unidade_controle_jogo_pkg;

    localparam int TIMEOUT_CYCLES_DEF = 5000;
    localparam int TW_DEF             = 13;

    // 4-bit state codes as they appear on db_estado.
    localparam logic [3:0] ST_INICIAL     = 4'b0000;
    localparam logic [3:0] ST_PREPARA     = 4'b0001;
    localparam logic [3:0] ST_ESPERA      = 4'b0010;
    localparam logic [3:0] ST_REGISTRA    = 4'b0100;
    localparam logic [3:0] ST_COMPARA     = 4'b0101;
    localparam logic [3:0] ST_PROXIMO     = 4'b0110;
    localparam logic [3:0] ST_FIM_ACERTO  = 4'b1010;
    localparam logic [3:0] ST_FIM_ERRO    = 4'b1110;
    localparam logic [3:0] ST_FIM_TIMEOUT = 4'b1101;

    typedef enum logic [3:0] {
        INICIAL     = ST_INICIAL,
        PREPARA     = ST_PREPARA,
        ESPERA      = ST_ESPERA,
        REGISTRA    = ST_REGISTRA,
        COMPARA     = ST_COMPARA,
        PROXIMO     = ST_PROXIMO,
        FIM_ACERTO  = ST_FIM_ACERTO,
        FIM_ERRO    = ST_FIM_ERRO,
        FIM_TIMEOUT = ST_FIM_TIMEOUT
    } estado_t;

endpackage

// File: rtl/unidade_controle_jogo_contador_timeout.sv
// Per-move timeout counter: synchronous clear has priority over enable,
// and fim_o flags the last allowed waiting cycle (TIMEOUT_CYCLES-1).
module contador_timeout
    import unidade_controle_jogo_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
    parameter int TW             = TW_DEF
) (
    input  logic clock,
    input  logic reset,
    input  logic zera_i,
    input  logic conta_i,
    output logic fim_o
);

    localparam logic [TW-1:0] ULTIMO = TW'(TIMEOUT_CYCLES - 1);

    logic [TW-1:0] cnt_q;
    logic [TW-1:0] cnt_d;

    // Next count: clear wins, otherwise increment only while enabled.
    always_comb begin
        cnt_d = cnt_q;
        if (zera_i) begin
            cnt_d = '0;
        end else if (conta_i) begin
            cnt_d = cnt_q + TW'(1);
        end
    end

    // Count register with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign fim_o = (cnt_q == ULTIMO);

endmodule

// File: rtl/unidade_controle_jogo.sv
// Moore control unit for one memory-compare round: waits for each move,
// registers it, compares it with the current ROM word and either advances
// the address or ends the round (hit, miss or timeout).
module unidade_controle_jogo
    import unidade_controle_jogo_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
    parameter int TW             = TW_DEF
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic       jogada,
    input  logic       igual,
    input  logic       fimC,
    output logic       zeraC,
    output logic       contaC,
    output logic       zeraR,
    output logic       registraR,
    output logic       pronto,
    output logic       acertou,
    output logic       errou,
    output logic       timeout,
    output logic [3:0] db_estado
);

    estado_t estado_q;
    estado_t estado_d;

    logic zera_tmo;
    logic conta_tmo;
    logic fim_tmo;

    // The counter is cleared whenever a new waiting period is about to start
    // and advances only while a move is awaited, so it holds elsewhere.
    assign zera_tmo  = (estado_q == PREPARA) || (estado_q == PROXIMO);
    assign conta_tmo = (estado_q == ESPERA);

    contador_timeout #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .TW             (TW)
    ) u_contador_timeout (
        .clock   (clock),
        .reset   (reset),
        .zera_i  (zera_tmo),
        .conta_i (conta_tmo),
        .fim_o   (fim_tmo)
    );

    // State register; reset returns to INICIAL from anywhere, even mid-round.
    always_ff @(posedge clock) begin
        if (!reset) begin
            estado_q <= INICIAL;
        end else begin
            estado_q <= estado_d;
        end
    end

    // Next-state logic and Moore output decode (outputs depend on estado_q only).
    always_comb begin
        estado_d  = estado_q;
        zeraC     = 1'b0;
        contaC    = 1'b0;
        zeraR     = 1'b0;
        registraR = 1'b0;
        pronto    = 1'b0;
        acertou   = 1'b0;
        errou     = 1'b0;
        timeout   = 1'b0;
        case (estado_q)
            INICIAL: begin
                if (iniciar) estado_d = PREPARA;
            end
            PREPARA: begin
                zeraC    = 1'b1;
                zeraR    = 1'b1;
                estado_d = ESPERA;
            end
            ESPERA: begin
                // A move arriving on the expiry cycle still counts.
                if (jogada) begin
                    estado_d = REGISTRA;
                end else if (fim_tmo) begin
                    estado_d = FIM_TIMEOUT;
                end
            end
            REGISTRA: begin
                registraR = 1'b1;
                estado_d  = COMPARA;
            end
            COMPARA: begin
                if (!igual) begin
                    estado_d = FIM_ERRO;
                end else if (fimC) begin
                    estado_d = FIM_ACERTO;
                end else begin
                    estado_d = PROXIMO;
                end
            end
            PROXIMO: begin
                contaC   = 1'b1;
                estado_d = ESPERA;
            end
            FIM_ACERTO: begin
                pronto  = 1'b1;
                acertou = 1'b1;
                if (iniciar) estado_d = PREPARA;
            end
            FIM_ERRO: begin
                pronto = 1'b1;
                errou  = 1'b1;
                if (iniciar) estado_d = PREPARA;
            end
            FIM_TIMEOUT: begin
                pronto  = 1'b1;
                timeout = 1'b1;
                if (iniciar) estado_d = PREPARA;
            end
            default: begin
                estado_d = INICIAL;
            end
        endcase
    end

    assign db_estado = estado_q;

endmodule

// File: tb/tb_unidade_controle_jogo.sv
// Bench for unidade_controle_jogo: a round-level reference model scripts the
// expected state of every cycle from a list of moves, the driver pushes each
// expectation as it drives the cycle, and a monitor compares at negedge.
module tb_unidade_controle_jogo;
    import unidade_controle_jogo_pkg::*;

    localparam int T   = 8;
    localparam int TWB = 4;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       iniciar = 1'b0;
    logic       jogada = 1'b0;
    logic       igual = 1'b0;
    logic       fimC = 1'b0;
    logic       zeraC, contaC, zeraR, registraR;
    logic       pronto, acertou, errou, timeout;
    logic [3:0] db_estado;

    // Clock and DUT.
    always #5 clock = ~clock;

    unidade_controle_jogo #(
        .TIMEOUT_CYCLES (T),
        .TW             (TWB)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .iniciar   (iniciar),
        .jogada    (jogada),
        .igual     (igual),
        .fimC      (fimC),
        .zeraC     (zeraC),
        .contaC    (contaC),
        .zeraR     (zeraR),
        .registraR (registraR),
        .pronto    (pronto),
        .acertou   (acertou),
        .errou     (errou),
        .timeout   (timeout),
        .db_estado (db_estado)
    );

    // Scoreboard state.
    logic [11:0] exp_q[$];
    logic [11:0] exp_v;
    logic [11:0] act_v;
    int vectors = 0;
    int miscompares = 0;
    int conta_seen = 0;
    int cyc = 0;

    // Round description consumed by play_round.
    int   dly[16];
    bit   ok_v[16];
    logic [3:0] fin;

    // Output table per state: {zeraC,contaC,zeraR,registraR,pronto,acertou,errou,timeout}.
    function automatic logic [7:0] saidas(input logic [3:0] st);
        case (st)
            ST_PREPARA:     return 8'b1010_0000;
            ST_REGISTRA:    return 8'b0001_0000;
            ST_PROXIMO:     return 8'b0100_0000;
            ST_FIM_ACERTO:  return 8'b0000_1100;
            ST_FIM_ERRO:    return 8'b0000_1010;
            ST_FIM_TIMEOUT: return 8'b0000_1001;
            default:        return 8'b0000_0000;
        endcase
    endfunction

    function automatic logic rnd();
        return 1'($urandom_range(0, 1));
    endfunction

    // Monitor: every cycle with a pending expectation is compared at negedge.
    always @(negedge clock) begin
        cyc <= cyc + 1;
        if (exp_q.size() > 0) begin
            exp_v = exp_q.pop_front();
            act_v = {db_estado, zeraC, contaC, zeraR, registraR,
                     pronto, acertou, errou, timeout};
            vectors++;
            if (act_v !== exp_v) begin
                miscompares++;
                $display("FAIL state_outs cycle %0d: got estado=%b outs=%b, expected estado=%b outs=%b",
                         cyc, act_v[11:8], act_v[7:0], exp_v[11:8], exp_v[7:0]);
            end
            if (contaC === 1'b1) conta_seen++;
        end
    end

    // Driver: drive one cycle's inputs and push the state expected in that cycle.
    task automatic cycle(input logic rst, input logic ini, input logic jog,
                         input logic ig, input logic fc, input logic [3:0] st);
        @(posedge clock);
        #1;
        reset   = rst;
        iniciar = ini;
        jogada  = jog;
        igual   = ig;
        fimC    = fc;
        exp_q.push_back({st, saidas(st)});
    endtask

    task automatic check_int(input string name, input int got, input int want);
        vectors++;
        if (got != want) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", name, got, want);
        end
    endtask

    // Reference model of one round: starting in a resting state, iniciar is
    // held 'hold' cycles; move i is made after dly[i] waiting cycles
    // (dly >= T means never) and is correct when ok_v[i].
    task automatic play_round(input logic [3:0] rest, input int hold, input string name);
        int  k;
        int  contas;
        bit  done;
        @(negedge clock);
        #1;
        conta_seen = 0;
        k = 0;
        contas = 0;
        done = 0;
        cycle(1, 1, rnd(), rnd(), rnd(), rest);                k++;
        cycle(1, 1'(k < hold), rnd(), rnd(), rnd(), ST_PREPARA); k++;
        fin = ST_FIM_ACERTO;
        for (int i = 0; i < 16 && !done; i++) begin
            for (int w = 0; w < T; w++) begin
                cycle(1, 1'(k < hold), 1'(w == dly[i]), rnd(), rnd(), ST_ESPERA);
                k++;
                if (w == dly[i]) break;
            end
            if (dly[i] >= T) begin
                fin = ST_FIM_TIMEOUT;
                done = 1;
            end else begin
                cycle(1, 1'(k < hold), rnd(), rnd(), rnd(), ST_REGISTRA); k++;
                cycle(1, 1'(k < hold), rnd(), ok_v[i], 1'(i == 15), ST_COMPARA); k++;
                if (!ok_v[i]) begin
                    fin = ST_FIM_ERRO;
                    done = 1;
                end else if (i == 15) begin
                    done = 1;
                end else begin
                    cycle(1, 1'(k < hold), rnd(), rnd(), rnd(), ST_PROXIMO);
                    k++;
                    contas++;
                end
            end
        end
        // The final state must hold while iniciar stays low, stray moves included.
        for (int j = 0; j < 3; j++) cycle(1, 0, rnd(), rnd(), rnd(), fin);
        @(negedge clock);
        #1;
        check_int(name, conta_seen, contas);
    endtask

    // Watchdog so the run can never hang.
    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Test sequence.
    initial begin
        reset = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b1;

        // Stray moves in INICIAL change nothing.
        for (int i = 0; i < 5; i++) cycle(1, 0, 1'(i % 2 == 0), rnd(), rnd(), ST_INICIAL);

        // Full correct round, moves immediate.
        for (int i = 0; i < 16; i++) begin dly[i] = 0; ok_v[i] = 1; end
        play_round(ST_INICIAL, 1, "contaC_full_round");
        check_int("fin_full_round", int'(fin), int'(ST_FIM_ACERTO));

        // Error on the third move.
        for (int i = 0; i < 16; i++) begin dly[i] = $urandom_range(0, 3); ok_v[i] = 1; end
        ok_v[2] = 0;
        play_round(fin, 1, "contaC_error_3rd");

        // Restart from FIM_ERRO with iniciar held 3 cycles, then no move at all.
        dly[0] = T + 5;
        play_round(fin, 3, "contaC_timeout");

        // Move on the last waiting cycle wins over expiry; next move wrong.
        dly[0] = T - 1; ok_v[0] = 1;
        dly[1] = 0;     ok_v[1] = 0;
        play_round(fin, 2, "contaC_late_move");

        // Reset mid-round from ESPERA.
        cycle(1, 1, 0, 0, 0, fin);
        cycle(1, 0, 0, 0, 0, ST_PREPARA);
        cycle(1, 0, 0, 0, 0, ST_ESPERA);
        cycle(0, 0, 0, 0, 0, ST_ESPERA);
        for (int i = 0; i < 5; i++) cycle(1, 0, 0, rnd(), rnd(), ST_INICIAL);
        fin = ST_INICIAL;

        // Randomized rounds.
        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < 16; i++) begin
                dly[i]  = ($urandom_range(0, 24) == 0) ? T + 1 : int'($urandom_range(0, T - 1));
                ok_v[i] = ($urandom_range(0, 19) != 0);
            end
            play_round(fin, int'($urandom_range(1, 3)), "contaC_random");
        end

        @(negedge clock);
        #1;
        check_int("exp_q_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/unidade_controle_jogo.md
Name: unidade_controle_jogo

Overview:
- Moore control unit that sequences the memory-compare datapath: address counter, 16-word ROM, switch register and equality comparator.
- Runs one round. Each cycle of a round waits for a player move, registers it, compares it against the current memory word, then either advances the address or ends the round.
- Adds a per-move timeout.
- Sits between the top level (iniciar, debug displays) and the datapath.

Parameters:
- TIMEOUT_CYCLES, 5000, clock cycles allowed in ESPERA before the round ends in timeout (minimum 2).
- TW, 13, width of the internal timeout counter; must satisfy 2^TW > TIMEOUT_CYCLES.

Ports:
- clock  in  1  system clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-low reset, sampled on the rising edge of clock.
- iniciar  in  1  start request; level-sampled.
- jogada  in  1  one-cycle pulse from the datapath switch-edge detector.
- igual  in  1  comparator output (registered switches == memory word).
- fimC  in  1  address counter at its last value (15).
- zeraC  out  1  clear address counter.
- contaC  out  1  increment address counter.
- zeraR  out  1  clear switch register.
- registraR  out  1  load switch register.
- pronto  out  1  round finished.
- acertou  out  1  round finished with all 16 moves correct.
- errou  out  1  round finished by a wrong move.
- timeout  out  1  round finished by timeout.
- db_estado  out  4  current state code, for the debug display.

Behaviour:
- All outputs are Moore outputs, decoded from the state register only. No output depends combinationally on an input.
- Reset: reset==0 at a rising edge forces INICIAL and clears the timeout counter. This applies from any state, including mid-round.
  - In INICIAL every output is 0 and db_estado=0000.
- State codes and transitions:
  - INICIAL 0000: iniciar=1 -> PREPARA, else stay.
  - PREPARA 0001: zeraC=1, zeraR=1, timeout counter cleared. -> ESPERA unconditionally.
  - ESPERA 0010: timeout counter increments once per cycle.
    - jogada=1 -> REGISTRA.
    - Otherwise, when the counter reaches TIMEOUT_CYCLES-1 -> FIM_TIMEOUT.
    - If jogada=1 and expiry occur in the same cycle, jogada wins.
  - REGISTRA 0100: registraR=1. -> COMPARA.
  - COMPARA 0101: decide on igual and fimC.
    - igual=0 -> FIM_ERRO.
    - igual=1, fimC=1 -> FIM_ACERTO.
    - igual=1, fimC=0 -> PROXIMO.
  - PROXIMO 0110: contaC=1, timeout counter cleared. -> ESPERA.
  - FIM_ACERTO 1010: pronto=1, acertou=1.
  - FIM_ERRO 1110: pronto=1, errou=1.
  - FIM_TIMEOUT 1101: pronto=1, timeout=1.
  - In all three final states: iniciar=1 -> PREPARA (restart without reset), else stay.
  - Unused codes -> INICIAL.
- Timing:
  - Timeout counter counts only in ESPERA and holds elsewhere, so ESPERA entered at cycle t with no jogada exits at t+TIMEOUT_CYCLES.
  - Latency from jogada pulse to the comparison decision is 2 cycles: REGISTRA, then COMPARA.
  - Per correct non-final move, ESPERA→ESPERA takes 4 cycles with jogada immediate.
- Pulse and level rules:
  - jogada pulses outside ESPERA are ignored; there is no queuing.
  - iniciar held high in INICIAL or a final state produces exactly one PREPARA entry. A held iniciar does not restart the round again, because it is not sampled in ESPERA or later.
- Exactly one of acertou, errou and timeout is high whenever pronto=1; all three are 0 otherwise.

Decomposition:
- Shared package:
  - the 4-bit state code localparams (INICIAL…FIM_TIMEOUT), reused by the debug hex decoder and the bench;
  - the TIMEOUT_CYCLES default.
- One natural sub-module: contador_timeout.
  - Parameterised up-counter with synchronous clear and enable, and a terminal flag at TIMEOUT_CYCLES-1.
  - Same synchronous active-low reset.
- The FSM (state register, next-state logic, output decode) stays in unidade_controle_jogo.

Test Plan (TIMEOUT_CYCLES=8):
- Reset=0 for 1 edge from ESPERA mid-round -> next cycle db_estado=0000, all outputs 0; iniciar=0 held 5 cycles -> stays 0000.
- Full correct round:
  - stimulus: iniciar pulse, then 16 jogada pulses with igual=1, fimC=1 only on the 16th;
  - response: 15 contaC pulses; db_estado ends 1010; pronto=1, acertou=1, errou=0, timeout=0; holds until iniciar.
- Error on the 3rd move:
  - stimulus: iniciar, two correct moves, third move with igual=0;
  - response: db_estado=1110, errou=1, pronto=1; exactly 2 contaC pulses seen.
- Timeout:
  - stimulus: iniciar, then no jogada;
  - response: 8 cycles in 0010, then 1101 with timeout=1, pronto=1.
  - stimulus: jogada arriving in the 8th ESPERA cycle;
  - response: REGISTRA, not timeout.
- Restart from FIM_ERRO:
  - stimulus: iniciar=1 held 3 cycles;
  - response: one PREPARA (zeraC=zeraR=1 for 1 cycle), then stays in ESPERA; pronto and errou drop to 0.
- Stray pulses:
  - stimulus: jogada pulses in INICIAL and in COMPARA;
  - response: no state change caused, no registraR.
